// File: rtl/tmc_uart_rx_fifo_if.sv
// Character FIFO handshake between the UART receive front end (master) and the CPU PIO side (slave).
`timescale 1ns/1ps
interface tmc_uart_rx_fifo_if;
  logic [7:0] rx_char;
  logic       rx_fifo_empty;
  logic       rx_fifo_full;
  logic       rx_fifo_read;

  modport master (
    output rx_char,
    output rx_fifo_empty,
    output rx_fifo_full,
    input  rx_fifo_read
  );

  modport slave (
    input  rx_char,
    input  rx_fifo_empty,
    input  rx_fifo_full,
    output rx_fifo_read
  );
endinterface

// File: rtl/tmc_uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with TMC_UART_RX_PARITY_EN defined) feeding a first-word fall-through byte FIFO.
`timescale 1ns/1ps
module tmc_uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       rxd,
  tmc_uart_rx_fifo_if.master         fifo_if,
  output logic                       rx_overrun,
  output logic                       frame_err,
  output logic                       parity_err
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned DEPTH_N = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0]   HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]   BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef TMC_UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic               rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         mem_q [DEPTH_N];

  logic fall, stop_strobe, frame_good, parity_ok, full, pop, push;

`ifdef TMC_UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
  assign parity_ok  = (par_q == ^shift_q);
  assign parity_err = parity_err_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign fall = rxd_prev_q & ~rxd_sync_q;
  assign full = (count_q == DEPTH);
  assign pop  = fifo_if.rx_fifo_read & (count_q != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    stop_strobe = 1'b0;
`ifdef TMC_UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef TMC_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef TMC_UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          par_d   = rxd_sync_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d       = '0;
          stop_strobe = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  always_comb begin
    frame_good  = stop_strobe & rxd_sync_q;
    push        = frame_good & parity_ok & (~full | pop);
    overrun_d   = frame_good & parity_ok & full & ~pop;
    frame_err_d = stop_strobe & ~rxd_sync_q;
`ifdef TMC_UART_RX_PARITY_EN
    parity_err_d = frame_good & ~parity_ok;
`endif
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef TMC_UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= rxd;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef TMC_UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign fifo_if.rx_fifo_empty = (count_q == '0);
  assign fifo_if.rx_fifo_full  = full;
  assign fifo_if.rx_char       = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_overrun            = overrun_q;
  assign frame_err             = frame_err_q;

endmodule

// File: tb/tb_tmc_uart_rx_fifo.sv
// Directed bench for tmc_uart_rx_fifo at CLKS_PER_BIT=16, FIFO_AW=2 (parity cases when TMC_UART_RX_PARITY_EN is defined).
`timescale 1ns/1ps
module tb_tmc_uart_rx_fifo;
  localparam int unsigned CPB = 16;
  localparam int unsigned AW  = 2;
`ifdef TMC_UART_RX_PARITY_EN
  localparam int unsigned LAT_SPEC = 2 + CPB/2 + 9*CPB + 2 + CPB;
`else
  localparam int unsigned LAT_SPEC = 2 + CPB/2 + 9*CPB + 2;
`endif
  // Edge at which the stop bit is sampled and the byte pushed.
  localparam int unsigned PUSH_EDGE = LAT_SPEC - 1;

  logic clk = 1'b0;
  logic rst, rxd;
  logic rx_overrun, frame_err, parity_err;
  tmc_uart_rx_fifo_if bus ();

  tmc_uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .rxd         (rxd),
    .fifo_if     (bus),
    .rx_overrun  (rx_overrun),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ov_n = 0, fe_n = 0, pe_n = 0;

  always @(negedge clk) begin
    if (rx_overrun === 1'b1) ov_n++;
    if (frame_err  === 1'b1) fe_n++;
    if (parity_err === 1'b1) pe_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; each bit is held for CPB cycles.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic flip_par);
    logic pbit;
    pbit = (^d) ^ flip_par;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef TMC_UART_RX_PARITY_EN
    rxd = pbit;
    repeat (CPB) @(negedge clk);
`endif
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, bus.rx_char}, {24'd0, exp});
    bus.rx_fifo_read = 1'b1;
    @(negedge clk);
    bus.rx_fifo_read = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty"}, {31'd0, bus.rx_fifo_empty}, 32'd1);
    chk({tag, "_full"},  {31'd0, bus.rx_fifo_full},  32'd0);
    chk({tag, "_char"},  {24'd0, bus.rx_char},       32'd0);
    chk({tag, "_pulses"}, {29'd0, rx_overrun, frame_err, parity_err}, 32'd0);
  endtask

  int n, ov0, fe0, pe0;
  bit done;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    bus.rx_fifo_read = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with latency window
    n = 0;
    done = 0;
    fork
      send_byte(8'hA5, 1'b1, 1'b0);
      begin
        while (n < 400 && !done) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (bus.rx_fifo_empty === 1'b0) done = 1;
        end
      end
    join
    chk("a5_latency_in_window", {31'd0, (n >= LAT_SPEC - 1) && (n <= LAT_SPEC + 1)}, 32'd1);
    chk("a5_char", {24'd0, bus.rx_char}, 32'hA5);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty_after_pop", {31'd0, bus.rx_fifo_empty}, 32'd1);
    chk("a5_char_after_pop", {24'd0, bus.rx_char}, 32'h00);

    // Fill and overrun
    ov0 = ov_n;
    for (int b = 1; b <= 3; b++) send_byte(8'(b), 1'b1, 1'b0);
    chk("fill3_not_full", {31'd0, bus.rx_fifo_full}, 32'd0);
    send_byte(8'h04, 1'b1, 1'b0);
    chk("fill4_full", {31'd0, bus.rx_fifo_full}, 32'd1);
    chk("fill4_no_overrun", ov_n - ov0, 32'd0);
    send_byte(8'h05, 1'b1, 1'b0);
    chk("byte5_overrun_one_pulse", ov_n - ov0, 32'd1);
    chk("byte5_still_full", {31'd0, bus.rx_fifo_full}, 32'd1);
    pop_chk("ovr_pop1", 8'h01);
    pop_chk("ovr_pop2", 8'h02);
    pop_chk("ovr_pop3", 8'h03);
    pop_chk("ovr_pop4", 8'h04);
    chk("ovr_drained_empty", {31'd0, bus.rx_fifo_empty}, 32'd1);

    // Frame error, then a short glitch
    fe0 = fe_n;
    ov0 = ov_n;
    send_byte(8'h3C, 1'b0, 1'b0);
    chk("fe_one_pulse", fe_n - fe0, 32'd1);
    chk("fe_fifo_empty", {31'd0, bus.rx_fifo_empty}, 32'd1);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_empty", {31'd0, bus.rx_fifo_empty}, 32'd1);
    chk("glitch_no_fe", fe_n - fe0, 32'd1);
    chk("glitch_no_ovr", ov_n - ov0, 32'd0);

    // Simultaneous push and pop while full
    for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b), 1'b1, 1'b0);
    chk("sim_full_before", {31'd0, bus.rx_fifo_full}, 32'd1);
    ov0 = ov_n;
    fork
      send_byte(8'h15, 1'b1, 1'b0);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        @(negedge clk);
        bus.rx_fifo_read = 1'b1;
        @(negedge clk);
        bus.rx_fifo_read = 1'b0;
      end
    join
    chk("sim_still_full", {31'd0, bus.rx_fifo_full}, 32'd1);
    chk("sim_no_overrun", ov_n - ov0, 32'd0);
    pop_chk("sim_pop1", 8'h12);
    pop_chk("sim_pop2", 8'h13);
    pop_chk("sim_pop3", 8'h14);
    pop_chk("sim_pop4", 8'h15);
    chk("sim_drained_empty", {31'd0, bus.rx_fifo_empty}, 32'd1);

    // Reset during data bit 4 with a byte already queued
    send_byte(8'h55, 1'b1, 1'b0);
    chk("mid_queued", {24'd0, bus.rx_char}, 32'h55);
    fe0 = fe_n;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("mid_rst");
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_after_rst_empty", {31'd0, bus.rx_fifo_empty}, 32'd1);
    send_byte(8'h7E, 1'b1, 1'b0);
    chk("mid_no_fe", fe_n - fe0, 32'd0);
    pop_chk("mid_7e", 8'h7E);
    chk("mid_only_one_byte", {31'd0, bus.rx_fifo_empty}, 32'd1);

    // Parity
    pe0 = pe_n;
`ifdef TMC_UART_RX_PARITY_EN
    send_byte(8'h03, 1'b1, 1'b0);
    chk("par_good_no_err", pe_n - pe0, 32'd0);
    pop_chk("par_good_char", 8'h03);
    send_byte(8'h03, 1'b1, 1'b1);
    chk("par_bad_one_pulse", pe_n - pe0, 32'd1);
    chk("par_bad_empty", {31'd0, bus.rx_fifo_empty}, 32'd1);
`else
    send_byte(8'h03, 1'b1, 1'b0);
    pop_chk("nopar_char", 8'h03);
    chk("nopar_no_parity_pulses", pe_n, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
